// File: rtl/decode_op_pkg.sv
// Shared definitions for the sensor-command decoder.
//   state_t     : decoder FSM states (IDLE=0, PAYLOAD=1, DROP=2)
//   sensor_msb  : MSB position of the sensor field in a header word
//   op_msb      : MSB position of the opcode field in a header word
package decode_op_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    DROP    = 2'd2
  } state_t;

  function automatic int unsigned sensor_msb(input int unsigned data_w);
    return data_w - 1;
  endfunction

  function automatic int unsigned op_msb(input int unsigned data_w,
                                         input int unsigned sensor_w);
    return data_w - 1 - sensor_w;
  endfunction

endpackage

// File: rtl/decode_op_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clock  in   rising-edge clock
//   reset  in   synchronous active-low reset (flushes, clears held output)
//   push   in   write din (ignored while full)
//   pop    in   drop head (ignored while empty)
//   din    in   WIDTH-bit write data
//   dout   out  head entry; while empty, the last popped entry (0 after reset)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
module decode_op_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("decode_op_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Once drained, the consumer keeps seeing the entry it last took.
  assign dout = empty ? last_q : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decode_op_param.sv
// Sensor-command decoder: header word + LEN payload words in, tagged
// entries {sensor, opcode, word} out through a small FWFT FIFO.
//   clock        in   rising-edge clock
//   reset        in   synchronous active-low reset
//   decode_rdy   in   data_in valid; accepted when decode_rdy && !decode_busy
//   data_in      in   header or payload word
//   decode_busy  out  backpressure (FIFO full, never while dropping)
//   sensor_num   out  sensor tag of FIFO head
//   op_code      out  opcode tag of FIFO head
//   data_out     out  payload of FIFO head
//   data_rdy     out  FIFO non-empty
//   data_ack     in   pops head when data_rdy
//   cmd_done     out  1-cycle pulse, command fully pushed
//   cmd_err      out  1-cycle pulse, illegal opcode header seen
module decode_op_param
  import decode_op_pkg::*;
#(
  parameter int unsigned        DATA_W        = 16,
  parameter int unsigned        SENSOR_W      = 2,
  parameter int unsigned        OP_W          = 3,
  parameter int unsigned        LEN_W         = 4,
  parameter int unsigned        FIFO_DEPTH    = 4,
  parameter logic [2**OP_W-1:0] OP_VALID_MASK = 8'h7F
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                decode_rdy,
  input  logic [DATA_W-1:0]   data_in,
  output logic                decode_busy,
  output logic [SENSOR_W-1:0] sensor_num,
  output logic [OP_W-1:0]     op_code,
  output logic [DATA_W-1:0]   data_out,
  output logic                data_rdy,
  input  logic                data_ack,
  output logic                cmd_done,
  output logic                cmd_err
);

  localparam int unsigned S_MSB = sensor_msb(DATA_W);
  localparam int unsigned O_MSB = op_msb(DATA_W, SENSOR_W);
  localparam int unsigned E_W   = SENSOR_W + OP_W + DATA_W;

  if (SENSOR_W + OP_W + LEN_W > DATA_W) begin : g_bad_fields
    $error("decode_op_param: header fields do not fit in DATA_W");
  end

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [SENSOR_W-1:0] sensor_q;
  logic [OP_W-1:0]     op_q;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [SENSOR_W-1:0] hdr_sensor;
  logic [OP_W-1:0]     hdr_op;
  logic [LEN_W-1:0]    hdr_len;
  logic                op_legal;
  logic                accept;
  logic                push;
  logic                pop;
  logic [E_W-1:0]      entry;
  logic [E_W-1:0]      head;
  logic                fifo_full;
  logic                fifo_empty;

  assign hdr_sensor = data_in[S_MSB -: SENSOR_W];
  assign hdr_op     = data_in[O_MSB -: OP_W];
  assign hdr_len    = data_in[LEN_W-1:0];
  assign op_legal   = OP_VALID_MASK[hdr_op];

  // Discarded words must keep flowing even when the FIFO is full.
  assign decode_busy = fifo_full && (state_q != DROP);
  assign accept      = decode_rdy && !decode_busy;
  assign pop         = data_ack && !fifo_empty;

  assign data_rdy                         = !fifo_empty;
  assign {sensor_num, op_code, data_out}  = head;
  assign cmd_done                         = done_q;
  assign cmd_err                          = err_q;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    push    = 1'b0;
    entry   = '0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!op_legal) begin
            err_d = 1'b1;
            if (hdr_len != '0) begin
              state_d = DROP;
              rem_d   = hdr_len;
            end
          end else if (hdr_len == '0) begin
            push   = 1'b1;
            entry  = {hdr_sensor, hdr_op, {DATA_W{1'b0}}};
            done_d = 1'b1;
          end else begin
            state_d = PAYLOAD;
            rem_d   = hdr_len;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          push  = 1'b1;
          entry = {sensor_q, op_q, data_in};
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      sensor_q <= '0;
      op_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (state_q == IDLE && accept) begin
        sensor_q <= hdr_sensor;
        op_q     <= hdr_op;
      end
    end
  end

  decode_op_fifo #(
    .WIDTH (E_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (entry),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_decode_op_param.sv
module tb_decode_op_param;

  typedef struct packed {
    logic [1:0]  s;
    logic [2:0]  op;
    logic [15:0] d;
  } entry_t;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        decode_rdy;
  logic [15:0] data_in;
  logic        decode_busy;
  logic [1:0]  sensor_num;
  logic [2:0]  op_code;
  logic [15:0] data_out;
  logic        data_rdy;
  logic        data_ack;
  logic        cmd_done;
  logic        cmd_err;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model: expected FIFO contents, current command, pending pulses.
  entry_t      exp_q[$];
  entry_t      last_pop;
  logic [15:0] tx[$];
  logic [15:0] pl[$];
  int unsigned tx_idx;
  logic [1:0]  c_s;
  logic [2:0]  c_op;
  int unsigned c_len;
  bit          c_legal;
  bit          exp_done;
  bit          exp_err;
  int unsigned ack_mode;
  int unsigned rdy_pct;

  decode_op_param #(
    .DATA_W        (16),
    .SENSOR_W      (2),
    .OP_W          (3),
    .LEN_W         (4),
    .FIFO_DEPTH    (DEPTH),
    .OP_VALID_MASK (8'h7F)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .decode_rdy  (decode_rdy),
    .data_in     (data_in),
    .decode_busy (decode_busy),
    .sensor_num  (sensor_num),
    .op_code     (op_code),
    .data_out    (data_out),
    .data_rdy    (data_rdy),
    .data_ack    (data_ack),
    .cmd_done    (cmd_done),
    .cmd_err     (cmd_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic bit model_busy();
    bit in_drop;
    in_drop = !c_legal && tx_idx >= 1 && tx_idx <= c_len;
    return (exp_q.size() == DEPTH) && !in_drop;
  endfunction

  task automatic check_outputs();
    entry_t h;
    h = (exp_q.size() > 0) ? exp_q[0] : last_pop;
    chk("data_rdy",    {31'd0, data_rdy},    {31'd0, exp_q.size() > 0});
    chk("decode_busy", {31'd0, decode_busy}, {31'd0, model_busy()});
    chk("sensor_num",  {30'd0, sensor_num},  {30'd0, h.s});
    chk("op_code",     {29'd0, op_code},     {29'd0, h.op});
    chk("data_out",    {16'd0, data_out},    {16'd0, h.d});
    chk("cmd_done",    {31'd0, cmd_done},    {31'd0, exp_done});
    chk("cmd_err",     {31'd0, cmd_err},     {31'd0, exp_err});
  endtask

  // One clock: check state, drive inputs, predict the edge's effect.
  task automatic cycle();
    bit          rdy, ack, acc, pop;
    int unsigned k;
    check_outputs();
    rdy = (tx_idx < tx.size()) && ($urandom_range(99) < rdy_pct);
    if (rdy) data_in = tx[tx_idx];
    else     data_in = 16'($urandom);
    ack = (ack_mode == 1) || (ack_mode == 2 && $urandom_range(1) == 1);
    decode_rdy = rdy;
    data_ack   = ack;
    acc = rdy && !model_busy();
    pop = ack && exp_q.size() > 0;
    @(posedge clock);
    if (pop) last_pop = exp_q.pop_front();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (acc) begin
      k = tx_idx;
      tx_idx++;
      if (k == 0) begin
        if (!c_legal) exp_err = 1'b1;
        else if (c_len == 0) begin
          exp_q.push_back('{c_s, c_op, 16'h0000});
          exp_done = 1'b1;
        end
      end else if (c_legal) begin
        exp_q.push_back('{c_s, c_op, tx[k]});
        if (k == c_len) exp_done = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset(input int unsigned n);
    reset      = 1'b0;
    decode_rdy = 1'b0;
    data_ack   = 1'b0;
    repeat (n) begin
      @(posedge clock);
      exp_q.delete();
      tx.delete();
      last_pop = '0;
      tx_idx   = 0;
      c_legal  = 1'b1;
      c_len    = 0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      @(negedge clock);
      check_outputs();
    end
    reset = 1'b1;
  endtask

  // Header fields decoded arithmetically: sensor = top 2 bits, op = next 3,
  // len = low 4; only opcode 7 is illegal under the default mask.
  task automatic load_cmd(input logic [15:0] hdr);
    tx.delete();
    tx.push_back(hdr);
    foreach (pl[i]) tx.push_back(pl[i]);
    tx_idx  = 0;
    c_s     = 2'(hdr / 16384);
    c_op    = 3'((hdr / 2048) % 8);
    c_len   = hdr % 16;
    c_legal = (c_op != 3'd7);
  endtask

  task automatic send_all(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (tx_idx < tx.size() && n < budget) begin
      cycle();
      n++;
    end
    chk(tag, tx_idx, tx.size());
  endtask

  task automatic run_until_idx(input int unsigned idx, input int unsigned budget);
    int unsigned n = 0;
    while (tx_idx < idx && n < budget) begin
      cycle();
      n++;
    end
    chk("reach_idx", tx_idx, idx);
  endtask

  task automatic run_cycles(input int unsigned n);
    repeat (n) cycle();
  endtask

  initial begin
    reset      = 1'b0;
    decode_rdy = 1'b0;
    data_ack   = 1'b0;
    data_in    = '0;
    ack_mode   = 1;
    rdy_pct    = 100;
    last_pop   = '0;
    c_legal    = 1'b1;
    c_len      = 0;
    tx_idx     = 0;
    exp_done   = 1'b0;
    exp_err    = 1'b0;
    @(negedge clock);

    // Reset, then reset again mid-idle.
    do_reset(2);
    run_cycles(2);
    do_reset(2);
    chk("rst_busy",     {31'd0, decode_busy}, 32'd0);
    chk("rst_data_rdy", {31'd0, data_rdy},    32'd0);

    // Three-word command, consumer always ready.
    pl = '{16'd1, 16'd2, 16'd3};
    load_cmd(16'h5003);
    send_all("send_5003", 50);
    run_cycles(4);

    // Consumer stalled: FIFO fills, words 5 and 6 held back.
    ack_mode = 0;
    pl = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
    load_cmd(16'h5006);
    run_cycles(12);
    chk("stall_busy", {31'd0, decode_busy}, 32'd1);
    chk("stall_rdy",  {31'd0, data_rdy},    32'd1);
    chk("stall_head", {16'd0, data_out},    32'd1);
    ack_mode = 1;
    send_all("send_5006", 50);
    run_cycles(6);

    // Illegal opcode: payload dropped, error pulse; then a legal command.
    pl = '{16'd9, 16'd9};
    load_cmd(16'h3802);
    send_all("send_3802", 50);
    run_cycles(3);
    pl = '{16'd4};
    load_cmd(16'h5001);
    send_all("send_5001", 50);
    run_cycles(4);

    // Zero-length command yields a single zero-data entry.
    pl.delete();
    load_cmd(16'h8800);
    send_all("send_8800", 50);
    run_cycles(4);

    // Reset in the middle of a command discards it.
    ack_mode = 0;
    pl = '{16'd1, 16'd2, 16'd3};
    load_cmd(16'h5003);
    run_until_idx(2, 50);
    do_reset(1);
    chk("mid_rst_rdy", {31'd0, data_rdy}, 32'd0);
    ack_mode = 1;
    pl = '{16'd7};
    load_cmd(16'h5001);
    send_all("send_after_rst", 50);
    run_cycles(4);

    // Randomised commands with random upstream gaps and consumer stalls.
    ack_mode = 2;
    rdy_pct  = 70;
    for (int c = 0; c < 60; c++) begin
      logic [15:0] hdr;
      int unsigned len;
      len = ($urandom_range(9) == 0) ? $urandom_range(15) : $urandom_range(6);
      hdr = {2'($urandom), 3'($urandom), 7'($urandom), 4'(len)};
      pl.delete();
      for (int i = 0; i < int'(len); i++) pl.push_back(16'($urandom));
      load_cmd(hdr);
      send_all("send_rand", 400);
      if ($urandom_range(3) == 0) run_cycles($urandom_range(5));
    end

    ack_mode = 1;
    run_cycles(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
